// File: rtl/id_branch_ctrl.sv
// Decode-stage hazard and branch control: load-use stall, early branch
// resolution, one-cycle squash after redirect, and the ID/EX register.
module id_branch_ctrl #(
    parameter logic [31:0] BUBBLE = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] npc_in,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic        cond,
    output logic [31:0] cond_npc,
    output logic [31:0] ex_ir,
    output logic [31:0] ex_pc,
    output logic        ex_valid,
    output logic [15:0] bubble_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic        squash_q;
    logic [15:0] bcnt_q;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  ld_rd;
    logic        dead;
    logic        ld_ex;
    logic        is_beq;
    logic        is_bne;
    logic        is_j;
    logic        is_jr;
    logic        taken;
    logic [31:0] target;
    logic [31:0] br_off;

    assign op     = ir_in[31:26];
    assign rs     = ir_in[25:21];
    assign rt     = ir_in[20:16];
    assign ld_rd  = ex_ir[20:16];
    assign br_off = {{14{ir_in[15]}}, ir_in[15:0], 2'b00};

    assign dead  = (ir_in == BUBBLE) || squash_q;
    assign ld_ex = ex_valid && (ex_ir[31:26] == OP_LW) && (ld_rd != 5'd0);

    // Only ir_in and registered state feed the hazard check
    assign stall = !dead && ld_ex && ((ld_rd == rs) || (ld_rd == rt));

    assign is_beq = (op == OP_BEQ);
    assign is_bne = (op == OP_BNE);
    assign is_j   = (op == OP_J) || (op == OP_JAL);
    assign is_jr  = (op == OP_RTYPE) && (ir_in[5:0] == FN_JR);

    always_comb begin
        taken  = 1'b0;
        target = 32'd0;
        unique case (1'b1)
            is_beq: begin
                taken  = (rs_data == rt_data);
                target = npc_in + br_off;
            end
            is_bne: begin
                taken  = (rs_data != rt_data);
                target = npc_in + br_off;
            end
            is_j: begin
                taken  = 1'b1;
                target = {npc_in[31:28], ir_in[25:0], 2'b00};
            end
            is_jr: begin
                taken  = 1'b1;
                target = rs_data;
            end
            default: begin
                taken  = 1'b0;
                target = 32'd0;
            end
        endcase
    end

    assign cond     = !dead && !stall && taken;
    assign cond_npc = cond ? target : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ir    <= BUBBLE;
            ex_pc    <= 32'd0;
            ex_valid <= 1'b0;
            squash_q <= 1'b0;
            bcnt_q   <= 16'd0;
        end else begin
            squash_q <= cond;
            ex_pc    <= pc_in;
            if (dead || stall) begin
                ex_ir    <= BUBBLE;
                ex_valid <= 1'b0;
            end else begin
                ex_ir    <= ir_in;
                ex_valid <= 1'b1;
            end
            // Only inserted bubbles count, not bubbles arriving from fetch
            if ((squash_q || stall) && (bcnt_q != 16'hFFFF))
                bcnt_q <= bcnt_q + 16'd1;
        end
    end

    assign bubble_cnt = bcnt_q;

endmodule

// File: doc/id_branch_ctrl.md
ID_BRANCH_CTRL -- requirements
Module: id_branch_ctrl

Interface
REQ-001 SHALL have parameter BUBBLE, default 32'hFFFF_FFFF, instruction word treated as a no-op bubble.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 ir_in  in  32  instruction currently delivered by the fetch stage.
REQ-005 pc_in  in  32  address of ir_in.
REQ-006 npc_in  in  32  pc_in+4 from the fetch stage.
REQ-007 rs_data  in  32  register-file value of ir_in[25:21], already forwarded.
REQ-008 rt_data  in  32  register-file value of ir_in[20:16], already forwarded.
REQ-009 stall  out  1  to fetch: hold PC and instruction this cycle.
REQ-010 cond  out  1  to fetch: redirect taken this cycle.
REQ-011 cond_npc  out  32  redirect target, valid when cond=1.
REQ-012 ex_ir  out  32  registered instruction issued to EX.
REQ-013 ex_pc  out  32  registered PC of ex_ir.
REQ-014 ex_valid  out  1  ex_ir is a real instruction (not bubble).
REQ-015 bubble_cnt  out  16  saturating count of bubbles inserted.

Function
REQ-016 Current instruction is "dead" when ir_in==BUBBLE or squash_q=1; dead instructions SHALL cause stall=0, cond=0, and issue BUBBLE to EX.
REQ-017 Load-use hazard: ex_valid=1, ex_ir[31:26]==6'b100011, ex_ir[20:16]!=0, and ex_ir[20:16] equals ir_in[25:21] or ir_in[20:16] of a live instruction -> stall=1 combinationally.
REQ-018 While stall=1: cond SHALL be 0; at the edge ex_ir<=BUBBLE, ex_valid<=0, ex_pc<=pc_in; ir_in is expected unchanged next cycle.
REQ-019 Branch decode (live, not stalled): BEQ op 000100 taken when rs_data==rt_data; BNE op 000101 taken when unequal; J op 000010 and JAL op 000011 always; JR op 000000 funct 001000 always.
REQ-020 Targets: BEQ/BNE npc_in + ({{14{ir_in[15]}},ir_in[15:0],2'b00}) mod 2^32; J/JAL {npc_in[31:28],ir_in[25:0],2'b00}; JR rs_data.
REQ-021 cond/cond_npc SHALL be combinational, same cycle as ir_in; cond_npc=0 when cond=0.
REQ-022 Live, not-stalled instruction (branch or not) SHALL be issued at the edge: ex_ir<=ir_in, ex_pc<=pc_in, ex_valid<=1.
REQ-023 squash_q<=1 on any edge where cond=1, else 0; exactly one instruction following a taken redirect is squashed; no delay slot.
REQ-024 bubble_cnt increments by 1 on each edge where BUBBLE is issued due to stall or squash (not for ir_in==BUBBLE input); saturates at 16'hFFFF.
REQ-025 stall and cond SHALL never be 1 in the same cycle; hazard wins over branch.
REQ-026 Branch whose operand is a load destination in EX SHALL stall one cycle, then resolve with forwarded data.
REQ-027 No combinational path from cond to stall; stall depends only on ir_in and registered state.

Reset
REQ-028 rst=1 SHALL immediately force ex_ir=BUBBLE, ex_pc=0, ex_valid=0, squash_q=0, bubble_cnt=0; stall and cond then follow REQ-016..021 from ir_in.
REQ-029 Reset mid-squash or mid-stall SHALL discard the pending squash; first live instruction after release issues normally.

Verification
REQ-030 ir_in=ADD r3,r1,r2 (32'h0022_1820), pc_in=0x100 -> stall=0, cond=0; next cycle ex_ir=32'h0022_1820, ex_pc=0x100, ex_valid=1.
REQ-031 EX holds LW r5 (ex_ir[20:16]=5); ir_in=ADD using rs=5 -> stall=1, next ex_valid=0, bubble_cnt=1; following cycle same ADD issues.
REQ-032 ir_in=BEQ r1,r2,+3 at pc 0x200, rs_data=rt_data=7 -> cond=1, cond_npc=0x210; next ir_in (0x204 word) issued as BUBBLE, bubble_cnt+1; third cycle normal.
REQ-033 BNE with equal operands -> cond=0, branch issued; J 26'h000_0040 at npc 0x8000_0004 -> cond_npc=0x8000_0100; JR rs_data=0x1234 -> cond_npc=0x1234.
REQ-034 LW r4 in EX, ir_in=BEQ r4,r0 -> cycle1 stall=1,cond=0; cycle2 stall=0, cond per rs_data.
REQ-035 Force bubble_cnt to 16'hFFFF via 65535 stalls, one more stall -> stays 16'hFFFF; assert rst during squash cycle -> outputs reset values immediately, no squash after release.
